// File: rtl/ddr_deserializer_pkg.sv
// ddr_deserializer_pkg: shared constants and FSM encoding
// for the DDR input deserializer.
package ddr_deserializer_pkg;

  localparam int         DW_DEF   = 8;
  localparam logic [7:0] SYNC_DEF = 8'hBC;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/ddr_deserializer_yaddri.sv
// yaddri: DDR input capture; both pad samples of a cycle are
// re-registered together on the following rising edge.
module yaddri (
  input  logic       i_clk,
  input  logic       i_pad,
  output logic [1:0] o_pair
);

  logic rise;
  logic fall;

  always_ff @(posedge i_clk) rise <= i_pad;

  always_ff @(negedge i_clk) fall <= i_pad;

  // bit 0 is the earlier (rising-edge) sample
  always_ff @(posedge i_clk) o_pair <= {fall, rise};

endmodule

// File: rtl/ddr_deserializer.sv
// ddr_deserializer: DDR pad capture, word packing and alignment.
// Define DDRIN_SYNC_EN to build the HUNT/LOCK sync-word aligner.
module ddr_deserializer
  import ddr_deserializer_pkg::*;
#(
  parameter int            DW        = DW_DEF,
  parameter logic [DW-1:0] SYNC_WORD = DW'(SYNC_DEF)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pad,
  input  logic          i_bitslip,
  input  logic          i_resync,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_sync,
  output logic          o_locked
);

  localparam int            PW    = $clog2(DW / 2);
  localparam logic [PW-1:0] PLAST = PW'(DW / 2 - 1);

  logic [1:0]    pair;
  logic [DW:0]   sreg;
  logic [DW-1:0] even_w;
  logic [DW-1:0] odd_w;
  logic [DW-1:0] cand;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nx;
  logic          odd;
  logic          odd_nx;
  logic          stall;
  logic          stall_nx;
  logic          due;

  yaddri u_yaddri (
    .i_clk  (i_clk),
    .i_pad  (i_pad),
    .o_pair (pair)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sreg <= '0;
    else         sreg <= {sreg[DW-2:0], pair[0], pair[1]};
  end

  assign even_w = sreg[DW-1:0];
  assign odd_w  = sreg[DW:1];
  assign cand   = odd ? odd_w : even_w;
  assign due    = (pcnt == PLAST) && !stall;

  // A slip into the odd candidate costs one extra pair of
  // waiting; stall holds pcnt for that one cycle.
  always_comb begin
    pcnt_nx  = pcnt + 1'b1;
    if (due)   pcnt_nx = '0;
    if (stall) pcnt_nx = pcnt;
    odd_nx   = odd ^ i_bitslip;
    stall_nx = i_bitslip & ~odd;
  end

`ifdef DDRIN_SYNC_EN
  state_t state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= HUNT;
      pcnt     <= '0;
      odd      <= 1'b0;
      stall    <= 1'b0;
      o_valid  <= 1'b0;
      o_sync   <= 1'b0;
      o_data   <= '0;
      o_locked <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      if (state == HUNT) begin
        o_locked <= 1'b0;
        if (even_w == SYNC_WORD || odd_w == SYNC_WORD) begin
          odd      <= (even_w != SYNC_WORD);
          pcnt     <= '0;
          stall    <= 1'b0;
          o_data   <= SYNC_WORD;
          o_valid  <= 1'b1;
          o_sync   <= 1'b1;
          o_locked <= 1'b1;
          state    <= LOCK;
        end
      end else begin
        pcnt  <= pcnt_nx;
        odd   <= odd_nx;
        stall <= stall_nx;
        if (due) begin
          o_data  <= cand;
          o_valid <= 1'b1;
        end
        o_locked <= !i_resync;
        if (i_resync) state <= HUNT;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_resync, SYNC_WORD};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pcnt     <= '0;
      odd      <= 1'b0;
      stall    <= 1'b0;
      o_valid  <= 1'b0;
      o_sync   <= 1'b0;
      o_data   <= '0;
      o_locked <= 1'b0;
    end else begin
      pcnt     <= pcnt_nx;
      odd      <= odd_nx;
      stall    <= stall_nx;
      o_valid  <= due;
      o_sync   <= 1'b0;
      o_locked <= 1'b1;
      if (due) o_data <= cand;
    end
  end
`endif

endmodule
